// File: rtl/status_led_bank.sv
// Per-channel activity LED stretcher with heartbeat/force/off modes; optional PWM via STATUS_LED_PWM_EN.
// Latency: led registered from next-state values, so a trigger in IDLE lights the LED at the same edge.
// Backpressure: none; triggers and config writes are always accepted, and triggers during a phase only set pending.
module status_led_bank #(
    parameter int          NCH       = 4,
    parameter int          STRETCH_W = 22,
    parameter int          HB_W      = 27,
    parameter logic [3:0]  CFG_BASE  = 4'h4,
    parameter logic [1:0]  MODE_RST  = 2'd0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] trigger,
    input  logic           config_w,
    input  logic [7:0]     config_a,
    input  logic [7:0]     config_d,
    output logic [NCH-1:0] led
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    localparam logic [STRETCH_W-1:0] CNT_FULL = '1;

    state_e               state_q [NCH];
    state_e               state_d [NCH];
    logic [STRETCH_W-1:0] cnt_q   [NCH];
    logic [STRETCH_W-1:0] cnt_d   [NCH];
    logic [1:0]           mode_q  [NCH];
    logic [1:0]           mode_d  [NCH];
    logic [NCH-1:0]       pend_q, pend_d;
    logic [NCH-1:0]       force_q, force_d;
    logic [HB_W-1:0]      hb_q, hb_d;
    logic [NCH-1:0]       led_q, led_d;
    logic                 cfg_hit;
    logic [3:0]           cfg_idx;
    logic                 pwm_on;

    assign cfg_hit = config_w && (config_a[7:4] == CFG_BASE);
    assign cfg_idx = config_a[3:0];

    // Only indices 0..NCH-1 match a channel; larger indices fall through untouched.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            mode_d[i]  = mode_q[i];
            force_d[i] = force_q[i];
            if (cfg_hit && (cfg_idx == 4'(i))) begin
                mode_d[i]  = config_d[1:0];
                force_d[i] = config_d[2];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pend_d[i]  = pend_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (trigger[i]) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = CNT_FULL;
                        pend_d[i]  = 1'b0;
                    end
                end
                ST_ON: begin
                    pend_d[i] = pend_q[i] | trigger[i];
                    if (cnt_q[i] == '0) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = CNT_FULL;
                    end else begin
                        cnt_d[i] = cnt_q[i] - STRETCH_W'(1);
                    end
                end
                ST_OFF: begin
                    if (cnt_q[i] == '0) begin
                        // A trigger landing on the last gap cycle restarts with no idle bubble.
                        if (pend_q[i] | trigger[i]) begin
                            state_d[i] = ST_ON;
                            cnt_d[i]   = CNT_FULL;
                            pend_d[i]  = 1'b0;
                        end else begin
                            state_d[i] = ST_IDLE;
                        end
                    end else begin
                        cnt_d[i]  = cnt_q[i] - STRETCH_W'(1);
                        pend_d[i] = pend_q[i] | trigger[i];
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    assign hb_d = hb_q + HB_W'(1);

`ifdef STATUS_LED_PWM_EN
    logic [7:0] pwm_q, pwm_d;
    logic [7:0] duty_q, duty_d;

    always_comb begin
        pwm_d  = pwm_q + 8'd1;
        duty_d = duty_q;
        if (cfg_hit && (cfg_idx == 4'hF)) begin
            duty_d = config_d;
        end
    end

    assign pwm_on = (pwm_d < duty_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pwm_q  <= '0;
            duty_q <= 8'hFF;
        end else begin
            pwm_q  <= pwm_d;
            duty_q <= duty_d;
        end
    end
`else
    logic unused_cfg_d;
    assign unused_cfg_d = ^config_d[7:3];
    assign pwm_on       = 1'b1;
`endif

    // Mode and force are taken from their registered copies, so a new setting shows one edge after it lands.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < NCH; i++) begin
            case (mode_q[i])
                2'd0:    led_d[i] = (state_d[i] == ST_ON) & pwm_on;
                2'd1:    led_d[i] = hb_d[HB_W-1] & pwm_on;
                2'd2:    led_d[i] = force_q[i] & pwm_on;
                default: led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= MODE_RST;
            end
            force_q <= '0;
            hb_q    <= '0;
            led_q   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= mode_d[i];
            end
            force_q <= force_d;
            hb_q    <= hb_d;
            led_q   <= led_d;
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_status_led_bank.sv
// Directed bench for status_led_bank with NCH=4, STRETCH_W=3, HB_W=4, CFG_BASE=4'h4.
module tb_status_led_bank;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] trigger;
    logic       config_w;
    logic [7:0] config_a;
    logic [7:0] config_d;
    logic [3:0] led;

    int vectors = 0;
    int errors  = 0;

    logic [3:0] hb_m;
`ifdef STATUS_LED_PWM_EN
    logic [7:0] pwm_m;
    logic [7:0] duty_m = 8'hFF;
`endif

    status_led_bank #(
        .NCH(4), .STRETCH_W(3), .HB_W(4), .CFG_BASE(4'h4), .MODE_RST(2'd0)
    ) dut (
        .clk(clk), .rstn(rstn), .trigger(trigger), .config_w(config_w),
        .config_a(config_a), .config_d(config_d), .led(led)
    );

    always #5 clk = ~clk;

    // Reference counters: value they hold just after an edge equals what that edge made visible.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) hb_m <= '0;
        else       hb_m <= hb_m + 4'd1;
    end
`ifdef STATUS_LED_PWM_EN
    always @(posedge clk or negedge rstn) begin
        if (!rstn) pwm_m <= '0;
        else       pwm_m <= pwm_m + 8'd1;
    end
`endif

    function automatic logic [3:0] g(input logic [3:0] v);
`ifdef STATUS_LED_PWM_EN
        return v & {4{pwm_m < duty_m}};
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
        config_w = 1'b1;
        config_a = a;
        config_d = d;
        step();
        config_w = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; trigger = 4'b0001; config_w = 1'b0; config_a = '0; config_d = '0;
        #1 rstn = 1'b0;
        #2;
        vectors++;
        if (led !== 4'b0000) begin errors++; $display("FAIL reset_led: led=%b expected 0000", led); end
        repeat (2) @(posedge clk);
        #4;
        vectors++;
        if (led !== 4'b0000) begin errors++; $display("FAIL reset_hold: led=%b expected 0000", led); end
        rstn = 1'b1;
        step();
        trigger = 4'b0000;
        vectors++;
        if (led !== g(4'b0001)) begin errors++; $display("FAIL first_edge: led=%b expected %b", led, g(4'b0001)); end
        repeat (16) step();
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL first_drain: led=%b expected %b", led, g(4'b0000)); end
    endtask

    task automatic test_single_trigger();
        logic [3:0] exp;
        trigger = 4'b0001;
        step();
        trigger = 4'b0000;
        for (int k = 0; k < 17; k++) begin
            exp = {3'b000, (k < 8)};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL single_k%0d: led=%b expected %b", k, led, g(exp)); end
            if (k < 16) step();
        end
        trigger = 4'b0001;
        step();
        trigger = 4'b0000;
        vectors++;
        if (led !== g(4'b0001)) begin errors++; $display("FAIL idle_retrigger: led=%b expected %b", led, g(4'b0001)); end
        repeat (17) step();
    endtask

    task automatic test_held_trigger();
        logic [3:0] exp;
        trigger = 4'b0100;
        step();
        for (int k = 0; k < 48; k++) begin
            exp = {1'b0, ((k % 16) < 8), 2'b00};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL held_k%0d: led=%b expected %b", k, led, g(exp)); end
            step();
        end
        trigger = 4'b0000;
        repeat (17) step();
    endtask

    task automatic test_pending_in_gap();
        logic [3:0] exp;
        trigger = 4'b0010;
        step();
        trigger = 4'b0000;
        for (int k = 0; k < 32; k++) begin
            exp = {2'b00, ((k % 16) < 8), 1'b0};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL gap_k%0d: led=%b expected %b", k, led, g(exp)); end
            trigger = (k == 9) ? 4'b0010 : 4'b0000;
            step();
        end
        trigger = 4'b0000;
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL gap_end: led=%b expected %b", led, g(4'b0000)); end
    endtask

    task automatic test_config();
        logic [3:0] exp;
        cfg_write(8'h43, 8'h06);
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL cfg_delay: led=%b expected %b", led, g(4'b0000)); end
        step();
        vectors++;
        if (led !== g(4'b1000)) begin errors++; $display("FAIL cfg_force_on: led=%b expected %b", led, g(4'b1000)); end
        cfg_write(8'h47, 8'h05);
        step();
        vectors++;
        if (led !== g(4'b1000)) begin errors++; $display("FAIL cfg_idx_oob: led=%b expected %b", led, g(4'b1000)); end
        cfg_write(8'h53, 8'h00);
        step();
        vectors++;
        if (led !== g(4'b1000)) begin errors++; $display("FAIL cfg_wrong_page: led=%b expected %b", led, g(4'b1000)); end
        config_a = 8'h43; config_d = 8'h00;
        repeat (2) step();
        vectors++;
        if (led !== g(4'b1000)) begin errors++; $display("FAIL cfg_no_strobe: led=%b expected %b", led, g(4'b1000)); end
        cfg_write(8'h41, 8'h01);
        step();
        for (int k = 0; k < 24; k++) begin
            exp = {2'b10, hb_m[3], 1'b0};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL cfg_hb_k%0d: led=%b expected %b", k, led, g(exp)); end
            step();
        end
        cfg_write(8'h41, 8'h00);
        cfg_write(8'h43, 8'h00);
        step();
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL cfg_restore: led=%b expected %b", led, g(4'b0000)); end
    endtask

    task automatic test_same_cycle();
        logic [3:0] exp;
        cfg_write(8'h40, 8'h03);
        step();
        trigger = 4'b0001;
        step();
        trigger = 4'b0000;
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL mode3_off: led=%b expected %b", led, g(4'b0000)); end
        repeat (16) step();
        config_w = 1'b1; config_a = 8'h40; config_d = 8'h00; trigger = 4'b0001;
        step();
        config_w = 1'b0; trigger = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            exp = {3'b000, (k >= 1 && k <= 7)};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL same_cycle_k%0d: led=%b expected %b", k, led, g(exp)); end
            step();
        end
        repeat (8) step();
    endtask

    task automatic test_async_reset();
        logic [3:0] exp;
        cfg_write(8'h42, 8'h06);
        trigger = 4'b0001;
        step();
        trigger = 4'b0000;
        repeat (2) step();
        vectors++;
        if (led !== g(4'b0101)) begin errors++; $display("FAIL pre_reset: led=%b expected %b", led, g(4'b0101)); end
        #3 rstn = 1'b0;
`ifdef STATUS_LED_PWM_EN
        duty_m = 8'hFF;
`endif
        #1;
        vectors++;
        if (led !== 4'b0000) begin errors++; $display("FAIL async_reset: led=%b expected 0000", led); end
        @(posedge clk);
        #4 rstn = 1'b1;
        step();
        vectors++;
        if (led !== g(4'b0000)) begin errors++; $display("FAIL post_reset_mode: led=%b expected %b", led, g(4'b0000)); end
        trigger = 4'b0100;
        step();
        trigger = 4'b0000;
        vectors++;
        if (led !== g(4'b0100)) begin errors++; $display("FAIL post_reset_trig: led=%b expected %b", led, g(4'b0100)); end
        repeat (16) step();
        cfg_write(8'h41, 8'h01);
        step();
        for (int k = 0; k < 16; k++) begin
            exp = {2'b00, hb_m[3], 1'b0};
            vectors++;
            if (led !== g(exp)) begin errors++; $display("FAIL hb_restart_k%0d: led=%b expected %b", k, led, g(exp)); end
            step();
        end
        cfg_write(8'h41, 8'h00);
        step();
    endtask

    task automatic test_pwm();
        int on_cnt;
        int exp_cnt;
        cfg_write(8'h4F, 8'h40);
`ifdef STATUS_LED_PWM_EN
        duty_m  = 8'h40;
        exp_cnt = 64;
`else
        exp_cnt = 256;
`endif
        cfg_write(8'h40, 8'h06);
        repeat (2) step();
        on_cnt = 0;
        for (int k = 0; k < 256; k++) begin
            on_cnt += int'(led[0]);
            step();
        end
        vectors++;
        if (on_cnt !== exp_cnt) begin errors++; $display("FAIL pwm_duty: on_cycles=%0d expected %0d", on_cnt, exp_cnt); end
        vectors++;
        if (led[3:1] !== 3'b000) begin errors++; $display("FAIL pwm_others: led[3:1]=%b expected 000", led[3:1]); end
    endtask

    initial begin
        test_reset();
        test_single_trigger();
        test_held_trigger();
        test_pending_in_gap();
        test_config();
        test_same_cycle();
        test_async_reset();
        test_pwm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
